// File: rtl/slave_bus_demux_pkg.sv
// Shared types for the slave-side bus demultiplexer.
// Command/result bundles and the demux FSM state.
package slave_bus_demux_pkg;

  typedef struct packed {
    logic        valid;
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  byte_en;
  } bus_cmd_t;

  typedef struct packed {
    logic        done;
    logic        error;
    logic [31:0] rdata;
  } bus_result_t;

  localparam logic [31:0] ERR_RDATA_DEF = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_ERR
  } demux_state_t;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/slave_bus_demux_decoder.sv
// Combinational address decoder for the slave demux.
// Lowest matching slave index wins on overlapping windows.
module bus_addr_decoder
  import slave_bus_demux_pkg::*;
#(
  parameter int NUM_SLAVES = 4,
  parameter int IDX_W = idx_width(NUM_SLAVES),
  parameter logic [31:0] SLAVE_BASE [NUM_SLAVES] = '{default: 32'h0},
  parameter logic [31:0] SLAVE_MASK [NUM_SLAVES] = '{default: 32'h0}
) (
  input  logic [31:0]      addr,
  output logic             hit,
  output logic [IDX_W-1:0] index
);

  always_comb begin
    hit   = 1'b0;
    index = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if ((addr & SLAVE_MASK[i]) == SLAVE_BASE[i]) begin
        hit   = 1'b1;
        index = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/slave_bus_demux.sv
// Fans one master command out to NUM_SLAVES slaves by address,
// tracking the single outstanding transaction and its errors.
module slave_bus_demux
  import slave_bus_demux_pkg::*;
#(
  parameter int NUM_SLAVES = 4,
  parameter logic [31:0] SLAVE_BASE [NUM_SLAVES] = '{
    32'h0000_0000, 32'h1000_0000, 32'h2000_0000, 32'h8000_0000},
  parameter logic [31:0] SLAVE_MASK [NUM_SLAVES] = '{
    32'hF000_0000, 32'hF000_0000, 32'hF000_0000, 32'hF000_0000},
  parameter int TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_RDATA = ERR_RDATA_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  bus_cmd_t    masterCmd,
  output bus_result_t masterResult,
  output bus_cmd_t    slaveCmd [NUM_SLAVES],
  input  bus_result_t slaveResult [NUM_SLAVES],
  output logic        busError,
  output logic [31:0] errorAddr
);

  localparam int IDX_W = idx_width(NUM_SLAVES);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam bus_result_t ERR_RESULT = '{
    done: 1'b1, error: 1'b1, rdata: ERR_RDATA};

  demux_state_t     state;
  logic [IDX_W-1:0] sel_idx;
  logic [CW-1:0]    count;

  logic             dec_hit;
  logic [IDX_W-1:0] dec_idx;
  logic             route_en;
  logic [IDX_W-1:0] route_idx;
  logic             timeout;

  bus_addr_decoder #(
    .NUM_SLAVES (NUM_SLAVES),
    .IDX_W      (IDX_W),
    .SLAVE_BASE (SLAVE_BASE),
    .SLAVE_MASK (SLAVE_MASK)
  ) u_dec (
    .addr  (masterCmd.addr),
    .hit   (dec_hit),
    .index (dec_idx)
  );

  always_comb begin
    route_en     = 1'b0;
    route_idx    = dec_idx;
    timeout      = 1'b0;
    masterResult = '0;
    busError     = 1'b0;
    for (int i = 0; i < NUM_SLAVES; i++)
      slaveCmd[i] = '0;

    unique case (state)
      ST_IDLE: route_en = masterCmd.valid & dec_hit;
      ST_BUSY: begin
        route_en  = 1'b1;
        route_idx = sel_idx;
        timeout   = ~slaveResult[sel_idx].done
                  & (count == CNT_LAST);
      end
      ST_ERR: begin
        masterResult = ERR_RESULT;
        busError     = 1'b1;
      end
      default: ;
    endcase

    if (route_en) begin
      slaveCmd[route_idx] = masterCmd;
      if (slaveResult[route_idx].done)
        masterResult = slaveResult[route_idx];
    end

    // Abort the stalled slave in the same cycle the error is returned
    if (timeout) begin
      slaveCmd[route_idx].valid = 1'b0;
      masterResult = ERR_RESULT;
      busError     = 1'b1;
    end

    if (!rst_n) begin
      masterResult = '0;
      busError     = 1'b0;
      for (int i = 0; i < NUM_SLAVES; i++)
        slaveCmd[i] = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      sel_idx   <= '0;
      count     <= '0;
      errorAddr <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (masterCmd.valid) begin
            if (!dec_hit) begin
              errorAddr <= masterCmd.addr;
              state     <= ST_ERR;
            end else if (!slaveResult[dec_idx].done) begin
              sel_idx <= dec_idx;
              count   <= '0;
              state   <= ST_BUSY;
            end
          end
        end
        ST_BUSY: begin
          if (slaveResult[sel_idx].done) begin
            state <= ST_IDLE;
          end else if (timeout) begin
            errorAddr <= masterCmd.addr;
            state     <= ST_IDLE;
          end else if (count != CNT_MAX) begin
            count <= count + 1'b1;
          end
        end
        ST_ERR:  state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_slave_bus_demux.sv
// Randomised and directed bench for slave_bus_demux with
// a transaction-level reference model.
module tb_slave_bus_demux;
  import slave_bus_demux_pkg::*;

  localparam int NS  = 4;
  localparam int TMO = 8;
  localparam logic [31:0] BASE [NS] = '{
    32'h0000_0000, 32'h1000_0000, 32'h2000_0000, 32'h8000_0000};
  localparam logic [31:0] MASK [NS] = '{
    32'h7000_0000, 32'hF000_0000, 32'hF000_0000, 32'hF000_0000};
  localparam logic [31:0] ERRD = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        rst_n;
  bus_cmd_t    m_cmd;
  bus_result_t m_res;
  bus_cmd_t    s_cmd [NS];
  bus_result_t s_res [NS];
  logic        bus_err;
  logic [31:0] err_addr;

  int vecs = 0;
  int errs = 0;
  logic [31:0] model_ea = '0;

  always #5 clk = ~clk;

  slave_bus_demux #(
    .NUM_SLAVES     (NS),
    .SLAVE_BASE     (BASE),
    .SLAVE_MASK     (MASK),
    .TIMEOUT_CYCLES (TMO),
    .ERR_RDATA      (ERRD)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .masterCmd    (m_cmd),
    .masterResult (m_res),
    .slaveCmd     (s_cmd),
    .slaveResult  (s_res),
    .busError     (bus_err),
    .errorAddr    (err_addr)
  );

  task automatic chk(input string tag,
                     input logic [69:0] obs,
                     input logic [69:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int ref_decode(input logic [31:0] a);
    for (int i = 0; i < NS; i++)
      if ((a & MASK[i]) == BASE[i]) return i;
    return -1;
  endfunction

  function automatic bus_result_t noise();
    bus_result_t r;
    r.done  = 1'($urandom);
    r.error = 1'($urandom);
    r.rdata = $urandom;
    return r;
  endfunction

  function automatic bus_cmd_t mk(input logic [31:0] a,
                                  input logic w,
                                  input logic [31:0] d,
                                  input logic [3:0] be);
    bus_cmd_t c;
    c.valid = 1'b1;
    c.write = w;
    c.addr = a;
    c.wdata = d;
    c.byte_en = be;
    return c;
  endfunction

  // Entered and left at posedge+1; idle master, noisy slaves
  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      m_cmd = '0;
      for (int s = 0; s < NS; s++) s_res[s] = noise();
      @(negedge clk);
      for (int s = 0; s < NS; s++)
        chk("idle_slave_cmd", 70'(s_cmd[s]), 70'(0));
      chk("idle_result", 70'(m_res), 70'(0));
      chk("idle_bus_err", 70'(bus_err), 70'(0));
      chk("idle_err_addr", 70'(err_addr), 70'(model_ea));
      @(posedge clk); #1;
    end
  endtask

  // One transaction: slave 'lat' cycles after acceptance answers
  task automatic txn(input bus_cmd_t cmd, input int lat,
                     input logic [31:0] rd, input logic serr);
    int idx;
    int fin;
    bit tmo;
    bus_cmd_t ec;
    bus_result_t er;
    logic eb;
    idx = ref_decode(cmd.addr);
    tmo = (idx >= 0) && (lat > TMO);
    if (idx < 0) fin = 1;
    else if (tmo) fin = TMO;
    else fin = lat;
    m_cmd = cmd;
    for (int c = 0; c <= fin; c++) begin
      for (int s = 0; s < NS; s++) begin
        s_res[s] = noise();
        if (s == idx) begin
          s_res[s].done = (c == lat);
          if (c == lat) begin
            s_res[s].rdata = rd;
            s_res[s].error = serr;
          end
        end
      end
      @(negedge clk);
      for (int s = 0; s < NS; s++) begin
        ec = '0;
        if (s == idx) begin
          ec = cmd;
          if (tmo && c == fin) ec.valid = 1'b0;
        end
        chk("slave_cmd", 70'(s_cmd[s]), 70'(ec));
      end
      er = '0;
      eb = 1'b0;
      if (c == fin) begin
        if (idx < 0 || tmo) begin
          er = '{done: 1'b1, error: 1'b1, rdata: ERRD};
          eb = 1'b1;
        end else begin
          er = '{done: 1'b1, error: serr, rdata: rd};
        end
      end
      chk("master_result", 70'(m_res), 70'(er));
      chk("bus_error", 70'(bus_err), 70'(eb));
      chk("error_addr", 70'(err_addr), 70'(model_ea));
      if (idx < 0 && c == 0) model_ea = cmd.addr;
      if (tmo && c == fin) model_ea = cmd.addr;
      @(posedge clk); #1;
    end
    m_cmd = '0;
  endtask

  initial begin
    bus_cmd_t cmd;
    rst_n = 1'b0;
    m_cmd = mk(32'h1000_0000, 1'b0, 32'h0, 4'hF);
    for (int s = 0; s < NS; s++)
      s_res[s] = '{done: 1'b1, error: 1'b0, rdata: 32'h55};
    #3;
    for (int s = 0; s < NS; s++)
      chk("reset_slave_cmd", 70'(s_cmd[s]), 70'(0));
    chk("reset_result", 70'(m_res), 70'(0));
    chk("reset_bus_err", 70'(bus_err), 70'(0));
    chk("reset_err_addr", 70'(err_addr), 70'(0));
    m_cmd = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    idle(1);

    txn(mk(32'h1000_0040, 1'b0, 32'h0, 4'hF), 2, 32'h1234_5678, 1'b0);
    idle(1);
    txn(mk(32'h0000_0004, 1'b1, 32'hCAFE_0001, 4'h3), 0, 32'h0, 1'b0);
    txn(mk(32'h2000_0100, 1'b0, 32'h0, 4'hF), 1, 32'hA5A5_0002, 1'b0);
    txn(mk(32'h4000_0000, 1'b0, 32'h0, 4'hF), 0, 32'h0, 1'b0);
    idle(1);
    txn(mk(32'h2000_0010, 1'b1, 32'h1111_2222, 4'hF), 100, 32'h0, 1'b0);
    m_cmd = '0;
    for (int s = 0; s < NS; s++) s_res[s] = '0;
    s_res[2] = '{done: 1'b1, error: 1'b0, rdata: 32'h7777_7777};
    @(negedge clk);
    chk("late_done_result", 70'(m_res), 70'(0));
    chk("late_done_bus_err", 70'(bus_err), 70'(0));
    chk("late_done_err_addr", 70'(err_addr), 70'(32'h2000_0010));
    @(posedge clk); #1;
    txn(mk(32'h8000_0000, 1'b0, 32'h0, 4'hF), 1, 32'h0BAD_F00D, 1'b0);
    txn(mk(32'h1000_0000, 1'b0, 32'h0, 4'hF), 3, 32'h0000_0E00, 1'b1);
    txn(mk(32'h2000_0008, 1'b1, 32'h9999_0000, 4'h0), 2, 32'h0, 1'b0);
    txn(mk(32'h1000_0020, 1'b0, 32'h0, 4'hF), TMO, 32'h0000_0808, 1'b0);
    txn(mk(32'h1000_0024, 1'b0, 32'h0, 4'hF), TMO + 1, 32'h0, 1'b0);
    idle(2);

    cmd = mk(32'h2000_0040, 1'b0, 32'h0, 4'hF);
    m_cmd = cmd;
    for (int s = 0; s < NS; s++) s_res[s] = '0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    model_ea = '0;
    for (int s = 0; s < NS; s++)
      chk("midrst_slave_cmd", 70'(s_cmd[s]), 70'(0));
    chk("midrst_result", 70'(m_res), 70'(0));
    chk("midrst_bus_err", 70'(bus_err), 70'(0));
    chk("midrst_err_addr", 70'(err_addr), 70'(0));
    m_cmd = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    txn(mk(32'h2000_0044, 1'b0, 32'h0, 4'hF), 2, 32'h600D_600D, 1'b0);

    for (int n = 0; n < 150; n++) begin
      cmd = mk({4'($urandom), 28'($urandom)}, 1'($urandom),
               $urandom, 4'($urandom));
      txn(cmd, $urandom_range(0, TMO + 3), $urandom, 1'($urandom));
      idle($urandom_range(0, 2));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
